conv_window_ctrl: RTL

- Parametrised control path for the sliding-window convolver; replaces the fixed 3x3 weight/shift sequencer.
- Sequences kernel weight loading, then streams one image frame pixel-by-pixel into the datapath line buffers.
- Flags each cycle where the KxK window is complete and on the stride grid; supports output backpressure.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_pos_counter.sv | 69 ++++++
 rtl/conv_window_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and default geometry for the sliding-window convolver control path.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int KERNEL_SIZE_DEF = 5;
    localparam int IMG_WIDTH_DEF   = 28;
    localparam int IMG_HEIGHT_DEF  = 28;
    localparam int STRIDE_DEF      = 1;

    // Counter widths never collapse to zero bits, even for degenerate ranges.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W_DEF   = safe_clog2(IMG_WIDTH_DEF);
    localparam int ROW_W_DEF   = safe_clog2(IMG_HEIGHT_DEF);
    localparam int WADDR_W_DEF = safe_clog2(KERNEL_SIZE_DEF * KERNEL_SIZE_DEF);

endpackage

// File: rtl/conv_pos_counter.sv
// Pixel position tracker: column/row of the next pixel plus stride phase,
// flags the accepted pixel that completes an on-grid KxK window.
module conv_pos_counter
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int IMG_WIDTH   = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT  = IMG_HEIGHT_DEF,
    parameter int STRIDE      = STRIDE_DEF,
    localparam int COL_W      = safe_clog2(IMG_WIDTH),
    localparam int ROW_W      = safe_clog2(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             hit,
    output logic             last
);

    localparam int PH_W = safe_clog2(STRIDE);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_KM1  = COL_W'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_KM1  = ROW_W'(KERNEL_SIZE - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(STRIDE - 1);

    logic [PH_W-1:0] cp, rp, cp_nxt, rp_nxt;
    logic            col_wrap, row_wrap;

    assign col_wrap = (col == COL_LAST);
    assign row_wrap = (row == ROW_LAST);
    assign hit  = en && (row >= ROW_KM1) && (col >= COL_KM1) && (cp == '0) && (rp == '0);
    assign last = en && col_wrap && row_wrap;

    // Phase stays 0 until the first full window column/row, then counts modulo STRIDE.
    always_comb begin
        cp_nxt = '0;
        rp_nxt = '0;
        if (col >= COL_KM1 && cp != PH_LAST) cp_nxt = cp + 1'b1;
        if (row >= ROW_KM1 && rp != PH_LAST) rp_nxt = rp + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
            cp  <= '0;
            rp  <= '0;
        end else if (en) begin
            if (col_wrap) begin
                col <= '0;
                cp  <= '0;
                if (row_wrap) begin
                    row <= '0;
                    rp  <= '0;
                end else begin
                    row <= row + 1'b1;
                    rp  <= rp_nxt;
                end
            end else begin
                col <= col + 1'b1;
                cp  <= cp_nxt;
            end
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// Control path for the sliding-window convolver: kernel weight load sequencing,
// then one frame of pixels streamed with window-valid flagging and backpressure.
//
// state     | meaning
// ST_IDLE   | waiting for load_weights or start
// ST_LOAD_W | accepting K*K weight words, row-major
// ST_STREAM | accepting frame pixels, flagging window hits
// ST_FLUSH  | last pixel taken, draining the final result
// ST_DONE   | one-cycle frame_done pulse
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int IMG_WIDTH   = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT  = IMG_HEIGHT_DEF,
    parameter int STRIDE      = STRIDE_DEF,
    localparam int WADDR_W    = safe_clog2(KERNEL_SIZE * KERNEL_SIZE),
    localparam int COL_W      = safe_clog2(IMG_WIDTH),
    localparam int ROW_W      = safe_clog2(IMG_HEIGHT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_weights,
    input  logic               start,
    input  logic               wt_valid,
    output logic               wt_ready,
    output logic               wt_we,
    output logic [WADDR_W-1:0] wt_addr,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic               en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COL_W-1:0]   col,
    output logic [ROW_W-1:0]   row,
    output logic               busy,
    output logic               frame_done,
    output logic               start_err
);

    localparam logic [WADDR_W-1:0] WADDR_LAST = WADDR_W'(KERNEL_SIZE * KERNEL_SIZE - 1);

    state_t state, state_nxt;
    logic   wt_loaded;
    logic   hit, last;

    assign wt_we = wt_valid & wt_ready;
    assign en    = pix_valid & pix_ready;

    conv_pos_counter #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .IMG_WIDTH   (IMG_WIDTH),
        .IMG_HEIGHT  (IMG_HEIGHT),
        .STRIDE      (STRIDE)
    ) u_pos (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .col   (col),
        .row   (row),
        .hit   (hit),
        .last  (last)
    );

    always_comb begin
        state_nxt  = state;
        wt_ready   = 1'b0;
        pix_ready  = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (load_weights)            state_nxt = ST_LOAD_W;
                else if (start && wt_loaded) state_nxt = ST_STREAM;
            end
            ST_LOAD_W: begin
                wt_ready = 1'b1;
                if (wt_valid && wt_addr == WADDR_LAST) state_nxt = ST_IDLE;
            end
            ST_STREAM: begin
                // A held, unaccepted result blocks the window from sliding.
                pix_ready = !(out_valid && !out_ready);
                if (last) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!out_valid || out_ready) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wt_addr   <= '0;
            wt_loaded <= 1'b0;
            out_valid <= 1'b0;
            start_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            start_err <= (state == ST_IDLE) && !load_weights && start && !wt_loaded;
            out_valid <= hit || (out_valid && !out_ready);
            // A reload overwrites the kernel, so the old set is no longer usable.
            if (state == ST_IDLE && load_weights) wt_loaded <= 1'b0;
            if (wt_we) begin
                if (wt_addr == WADDR_LAST) begin
                    wt_addr   <= '0;
                    wt_loaded <= 1'b1;
                end else begin
                    wt_addr <= wt_addr + 1'b1;
                end
            end
        end
    end

endmodule
